// File: rtl/tod_peak_clock.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler, 12-hour/pm/peak-window decode and validated load.
// Time and pulses are registered (one-cycle load latency); hh/pm/peak decode combinationally from h24; no backpressure.
module tod_peak_clock #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int PK1_START   = 7,
    parameter int PK1_END     = 10,
    parameter int PK2_START   = 17,
    parameter int PK2_END     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       peak,
    output logic       sec_tick,
    output logic       load_err
);

    localparam int            PW  = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] TC  = PW'(CLK_PER_SEC - 1);
    localparam logic [4:0]    P1S = 5'(PK1_START);
    localparam logic [4:0]    P1E = 5'(PK1_END);
    localparam logic [4:0]    P2S = 5'(PK2_START);
    localparam logic [4:0]    P2E = 5'(PK2_END);

    logic [PW-1:0] presc;
    logic [4:0]    h24;
    logic [2:0]    m_t;
    logic [3:0]    m_u;
    logic [2:0]    s_t;
    logic [3:0]    s_u;

    logic       hh_ok;
    logic       mm_ok;
    logic       ss_ok;
    logic       set_ok;
    logic [4:0] h_ld;
    logic [4:0] h12;

    // Upper hour nibble is implied <= 2 by the 8'h23 bound.
    assign hh_ok  = (set_hh <= 8'h23) && (set_hh[3:0] <= 4'd9);
    assign mm_ok  = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);
    assign ss_ok  = (set_ss[7:4] <= 4'd5) && (set_ss[3:0] <= 4'd9);
    assign set_ok = hh_ok && mm_ok && ss_ok;
    assign h_ld   = ({3'b000, set_hh[5:4]} * 5'd10) + {1'b0, set_hh[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            h24      <= '0;
            m_t      <= '0;
            m_u      <= '0;
            s_t      <= '0;
            s_u      <= '0;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            load_err <= 1'b0;
            if (load && set_ok) begin
                presc <= '0;
                h24   <= h_ld;
                m_t   <= set_mm[6:4];
                m_u   <= set_mm[3:0];
                s_t   <= set_ss[6:4];
                s_u   <= set_ss[3:0];
            end else begin
                if (load) begin
                    load_err <= 1'b1;
                end
                if (ena) begin
                    if (presc == TC) begin
                        presc    <= '0;
                        sec_tick <= 1'b1;
                        // BCD cascade: seconds -> minutes -> hour, midnight wrap at 23.
                        if (s_u != 4'd9) begin
                            s_u <= s_u + 4'd1;
                        end else begin
                            s_u <= 4'd0;
                            if (s_t != 3'd5) begin
                                s_t <= s_t + 3'd1;
                            end else begin
                                s_t <= 3'd0;
                                if (m_u != 4'd9) begin
                                    m_u <= m_u + 4'd1;
                                end else begin
                                    m_u <= 4'd0;
                                    if (m_t != 3'd5) begin
                                        m_t <= m_t + 3'd1;
                                    end else begin
                                        m_t <= 3'd0;
                                        h24 <= (h24 == 5'd23) ? 5'd0 : h24 + 5'd1;
                                    end
                                end
                            end
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        h12 = h24;
        if (h24 == 5'd0) begin
            h12 = 5'd12;
        end else if (h24 > 5'd12) begin
            h12 = h24 - 5'd12;
        end
    end

    assign hh   = (h12 >= 5'd10) ? {4'h1, 4'(h12 - 5'd10)} : {4'h0, h12[3:0]};
    assign mm   = {1'b0, m_t, m_u};
    assign ss   = {1'b0, s_t, s_u};
    assign pm   = (h24 >= 5'd12);
    assign peak = ((h24 >= P1S) && (h24 < P1E)) || ((h24 >= P2S) && (h24 < P2E));

endmodule

// File: tb/tb_tod_peak_clock.sv
// Scoreboard bench for tod_peak_clock with CLK_PER_SEC=4: stimulus pushes expected snapshots,
// a negedge monitor pops one whenever a probe, sec_tick or load_err is seen.
module tb_tod_peak_clock;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic       peak;
        logic       tick;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       load;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       peak;
    logic       sec_tick;
    logic       load_err;

    logic  probe  = 1'b0;
    logic  mon_en = 1'b0;
    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    string nm[$];

    tod_peak_clock #(
        .CLK_PER_SEC(4),
        .PK1_START  (7),
        .PK1_END    (10),
        .PK2_START  (17),
        .PK2_END    (20)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ena     (ena),
        .load    (load),
        .set_hh  (set_hh),
        .set_mm  (set_mm),
        .set_ss  (set_ss),
        .hh      (hh),
        .mm      (mm),
        .ss      (ss),
        .pm      (pm),
        .peak    (peak),
        .sec_tick(sec_tick),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic p, input logic k, input logic t, input logic e);
        exp_t r;
        r.hh = h; r.mm = m; r.ss = s; r.pm = p; r.peak = k; r.tick = t; r.err = e;
        return r;
    endfunction

    // Monitor: one scoreboard entry per observed event or probe.
    always @(negedge clk) begin
        exp_t  act;
        exp_t  e;
        string n;
        if (mon_en && (probe || sec_tick === 1'b1 || load_err === 1'b1)) begin
            act = mk(hh, mm, ss, pm, peak, sec_tick, load_err);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: actual hh=%h mm=%h ss=%h pm=%b peak=%b tick=%b err=%b, required none",
                         act.hh, act.mm, act.ss, act.pm, act.peak, act.tick, act.err);
            end else begin
                e = sb.pop_front();
                n = nm.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: actual hh=%h mm=%h ss=%h pm=%b peak=%b tick=%b err=%b, required hh=%h mm=%h ss=%h pm=%b peak=%b tick=%b err=%b",
                             n, act.hh, act.mm, act.ss, act.pm, act.peak, act.tick, act.err,
                             e.hh, e.mm, e.ss, e.pm, e.peak, e.tick, e.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input exp_t e);
        sb.push_back(e);
        nm.push_back(n);
    endtask

    task automatic expect_now(input string n, input exp_t e);
        push(n, e);
        probe = 1'b1;
        cyc();
        probe = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load   = 1'b1;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        cyc();
        load   = 1'b0;
    endtask

    // Load with ena=1, check loaded value, then expect exactly one tick 4 cycles after the load edge.
    task automatic load_run(input string n, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input exp_t e_load, input exp_t e_tick);
        exp_t e_hold;
        ena = 1'b1;
        do_load(h, m, s);
        expect_now({n, "_load"}, e_load);
        push({n, "_tick"}, e_tick);
        repeat (3) cyc();
        ena = 1'b0;
        cyc();
        e_hold      = e_tick;
        e_hold.tick = 1'b0;
        expect_now({n, "_hold"}, e_hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        ena    = 1'b0;
        load   = 1'b0;
        set_hh = 8'h00;
        set_mm = 8'h00;
        set_ss = 8'h00;

        // 1. reset state and hold with ena=0
        repeat (2) cyc();
        mon_en = 1'b1;
        reset  = 1'b0;
        expect_now("reset_state", mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc();
            expect_now("reset_hold", mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // 2. midnight wrap: two ticks 4 cycles apart
        ena = 1'b1;
        do_load(8'h23, 8'h59, 8'h58);
        expect_now("load_235958", mk(8'h11, 8'h59, 8'h58, 1'b1, 1'b0, 1'b0, 1'b0));
        push("tick_235959", mk(8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 1'b1, 1'b0));
        push("tick_midnight", mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (7) cyc();
        ena = 1'b0;
        cyc();
        expect_now("hold_midnight", mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // 3. noon and 13:00 mapping
        load_run("noon", 8'h11, 8'h59, 8'h59,
                 mk(8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0),
                 mk(8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        load_run("one_pm", 8'h12, 8'h59, 8'h59,
                 mk(8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0),
                 mk(8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));

        // 4. peak window edges
        load_run("peak_start", 8'h06, 8'h59, 8'h59,
                 mk(8'h06, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0),
                 mk(8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        load_run("peak_end", 8'h09, 8'h59, 8'h59,
                 mk(8'h09, 8'h59, 8'h59, 1'b0, 1'b1, 1'b0, 1'b0),
                 mk(8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        do_load(8'h17, 8'h00, 8'h00);
        expect_now("load_1700", mk(8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));

        // 5. rejected loads while running; prescaler keeps counting
        push("err_hh24", mk(8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1));
        ena = 1'b1;
        do_load(8'h24, 8'h00, 8'h00);
        cyc();
        push("err_mm5a", mk(8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1));
        do_load(8'h17, 8'h5A, 8'h00);
        push("tick_after_err", mk(8'h05, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0));
        cyc();
        ena = 1'b0;
        cyc();
        expect_now("hold_after_err", mk(8'h05, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0));

        // 6a. load on terminal-count cycle suppresses the tick
        ena = 1'b1;
        repeat (3) cyc();
        do_load(8'h08, 8'h30, 8'h00);
        expect_now("load_on_tc", mk(8'h08, 8'h30, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
        push("tick_after_tc_load", mk(8'h08, 8'h30, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0));
        repeat (3) cyc();

        // 6b. reset mid-count, next tick 4 cycles after release
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_now("reset_midcount", mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        push("tick_after_reset", mk(8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (3) cyc();
        ena = 1'b0;
        cyc();
        expect_now("hold_after_reset", mk(8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));

        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0 (next: %s)", sb.size(), nm[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
